// File: rtl/pyramid_downsampler.sv
// 2:1 image pyramid step: reads a raster source from a fixed-latency BRAM and writes a
// half-resolution image, either by decimation or by 2x2 box averaging.
module pyramid_downsampler #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned HEIGHT     = 64,
  parameter int unsigned BIT_DEPTH  = 8,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                              clk_100mhz,
  input  logic                              sys_rst_n,
  input  logic                              start,
  input  logic                              mode,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   src_addr,
  output logic                              src_en,
  input  logic [BIT_DEPTH-1:0]              src_data,
  output logic [$clog2(WIDTH*HEIGHT/4)-1:0] dst_addr,
  output logic [BIT_DEPTH-1:0]              dst_data,
  output logic                              dst_we
);

  localparam int unsigned AW   = $clog2(WIDTH * HEIGHT);
  localparam int unsigned DAW  = $clog2(WIDTH * HEIGHT / 4);
  localparam int unsigned OW   = WIDTH / 2;
  localparam int unsigned OH   = HEIGHT / 2;
  localparam int unsigned NOUT = OW * OH;
  localparam int unsigned XW   = (OW > 1) ? $clog2(OW) : 1;
  localparam int unsigned YW   = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned SW   = BIT_DEPTH + 2;
  localparam int unsigned LAT  = RD_LATENCY;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [XW-1:0]      ox_q, ox_d, ox_n;
  logic [YW-1:0]      oy_q, oy_d, oy_n;
  logic [1:0]         sub_q, sub_d, sub_n;
  logic [AW-1:0]      src_addr_q, src_addr_d, addr_n;
  logic [DAW-1:0]     wr_cnt_q, dst_addr_q;
  logic [BIT_DEPTH-1:0] dst_data_q;
  logic               dst_we_q;
  logic [SW-1:0]      acc_q, sum;
  logic [LAT-1:0]     vld_q, lst_q;
  logic               last_x, last_y, grp_end, last_rd, last_wr, accept;

  assign last_x  = (ox_q == XW'(OW - 1));
  assign last_y  = (oy_q == YW'(OH - 1));
  // A group is one read when decimating, four reads (sub 0..3) when averaging.
  assign grp_end = !mode_q || (sub_q == 2'd3);
  assign last_rd = grp_end && last_x && last_y;
  assign last_wr = dst_we_q && (dst_addr_q == DAW'(NOUT - 1));
  assign accept  = (state_q == StIdle) && start;
  assign sum     = acc_q + SW'(src_data);

  // State register
  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (last_rd) state_d = StDrain;
      StDrain: if (last_wr) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    src_en = 1'b0;
    unique case (state_q)
      StIssue: begin
        busy   = 1'b1;
        src_en = 1'b1;
      end
      StDrain: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Read cursor advance: sub steps (0,0),(1,0),(0,1),(1,1) inside a 2x2 block
  always_comb begin
    sub_n = sub_q + 2'd1;
    ox_n  = ox_q;
    oy_n  = oy_q;
    if (grp_end) begin
      sub_n = 2'd0;
      if (last_x) begin
        ox_n = '0;
        oy_n = oy_q + YW'(1);
      end else begin
        ox_n = ox_q + XW'(1);
      end
    end
    addr_n = AW'(32'(ox_n) * 2 + 32'(sub_n[0]) + WIDTH * (32'(oy_n) * 2 + 32'(sub_n[1])));
  end

  always_comb begin
    mode_d     = mode_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    sub_d      = sub_q;
    src_addr_d = src_addr_q;
    if (accept) begin
      mode_d     = mode;
      ox_d       = '0;
      oy_d       = '0;
      sub_d      = '0;
      src_addr_d = '0;
    end else if ((state_q == StIssue) && !last_rd) begin
      ox_d       = ox_n;
      oy_d       = oy_n;
      sub_d      = sub_n;
      src_addr_d = addr_n;
    end
  end

  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q     <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      sub_q      <= '0;
      src_addr_q <= '0;
    end else begin
      mode_q     <= mode_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      sub_q      <= sub_d;
      src_addr_q <= src_addr_d;
    end
  end

  // In-flight read tags: the top bit lines up with the cycle src_data is valid.
  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_q      <= '0;
      lst_q      <= '0;
      acc_q      <= '0;
      wr_cnt_q   <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      dst_we_q   <= 1'b0;
    end else begin
      vld_q    <= (vld_q << 1) | LAT'(src_en);
      lst_q    <= (lst_q << 1) | LAT'(src_en & grp_end);
      dst_we_q <= 1'b0;
      if (accept) begin
        wr_cnt_q <= '0;
      end
      if (vld_q[LAT-1]) begin
        if (lst_q[LAT-1]) begin
          dst_we_q   <= 1'b1;
          dst_data_q <= mode_q ? sum[SW-1:2] : src_data;
          dst_addr_q <= wr_cnt_q;
          wr_cnt_q   <= wr_cnt_q + DAW'(1);
          acc_q      <= '0;
        end else begin
          acc_q <= sum;
        end
      end
    end
  end

  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
  assign dst_we   = dst_we_q;

endmodule

// File: tb/tb_pyramid_downsampler.sv
// Bench for pyramid_downsampler: two 4x4 instances (read latency 2 and 1) against a BRAM
// model, checked with constant vectors, a behavioural reference and a mid-pass reset.
module tb_pyramid_downsampler;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NO = W * H / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic mode = 1'b0;

  always #5 clk = ~clk;

  logic       busy_a, done_a, en_a, we_a, busy_b, done_b, en_b, we_b;
  logic [3:0] saddr_a, saddr_b;
  logic [1:0] daddr_a, daddr_b;
  logic [7:0] sdata_a, sdata_b, ddata_a, ddata_b;

  pyramid_downsampler #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(8), .RD_LATENCY(2)) u_dut_a (
    .clk_100mhz(clk), .sys_rst_n(rst_n), .start(start_a), .mode(mode),
    .busy(busy_a), .done(done_a), .src_addr(saddr_a), .src_en(en_a), .src_data(sdata_a),
    .dst_addr(daddr_a), .dst_data(ddata_a), .dst_we(we_a)
  );

  pyramid_downsampler #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(8), .RD_LATENCY(1)) u_dut_b (
    .clk_100mhz(clk), .sys_rst_n(rst_n), .start(start_b), .mode(mode),
    .busy(busy_b), .done(done_b), .src_addr(saddr_b), .src_en(en_b), .src_data(sdata_b),
    .dst_addr(daddr_b), .dst_data(ddata_b), .dst_we(we_b)
  );

  // Source BRAM models with 2- and 1-cycle read latency
  logic [7:0] src_mem [16];
  logic [7:0] pa1 = 8'd0;
  logic [7:0] pa2 = 8'd0;
  logic [7:0] pb1 = 8'd0;
  always @(posedge clk) begin
    if (en_a) pa1 <= src_mem[saddr_a];
    pa2 <= pa1;
    if (en_b) pb1 <= src_mem[saddr_b];
  end
  assign sdata_a = pa2;
  assign sdata_b = pb1;

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Observation of each instance, relative to the start cycle t0
  logic       active = 1'b0;
  int         t0 = 0;
  int         rd_cnt[2], rd_first[2], rd_last[2], rd_err[2];
  int         wr_cnt[2], wr_err[2], done_cnt[2], done_cyc[2];
  int         busy_first[2], busy_last[2], busy_at_done[2];
  logic [7:0] cap[2][4];
  int         exp_rd[16];
  int         exp_n = 0;
  int         exp_dst[4];

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      rd_cnt[i] = 0; rd_first[i] = 0; rd_last[i] = 0; rd_err[i] = 0;
      wr_cnt[i] = 0; wr_err[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0;
      busy_first[i] = -1; busy_last[i] = -1; busy_at_done[i] = 0;
      for (int k = 0; k < 4; k++) cap[i][k] = 8'd0;
    end
  endtask

  task automatic mon(input int i, input logic b, input logic d, input logic e,
                     input logic [3:0] sa, input logic we, input logic [1:0] da,
                     input logic [7:0] dd);
    int rel;
    rel = gcyc - t0;
    if (e) begin
      if (rd_cnt[i] == 0) rd_first[i] = rel;
      rd_last[i] = rel;
      if (rd_cnt[i] >= exp_n) rd_err[i]++;
      else if (int'(sa) != exp_rd[rd_cnt[i]]) rd_err[i]++;
      rd_cnt[i]++;
    end
    if (we) begin
      if (int'(da) != wr_cnt[i]) wr_err[i]++;
      cap[i][da] = dd;
      wr_cnt[i]++;
    end
    if (b) begin
      if (busy_first[i] < 0) busy_first[i] = rel;
      busy_last[i] = rel;
    end
    if (d) begin
      done_cnt[i]++;
      done_cyc[i] = rel;
      if (b) busy_at_done[i]++;
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      mon(0, busy_a, done_a, en_a, saddr_a, we_a, daddr_a, ddata_a);
      mon(1, busy_b, done_b, en_b, saddr_b, we_b, daddr_b, ddata_b);
    end
  end

  // Reference: raster walk over output pixels, reading each 2x2 block (or its corner)
  task automatic build_model(input logic m);
    int s, a;
    exp_n = 0;
    for (int oy = 0; oy < H / 2; oy++) begin
      for (int ox = 0; ox < W / 2; ox++) begin
        s = 0;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            if (m || (dx == 0 && dy == 0)) begin
              a = (2 * ox + dx) + W * (2 * oy + dy);
              exp_rd[exp_n] = a;
              exp_n++;
              s += int'(src_mem[a]);
            end
          end
        end
        exp_dst[ox + (W / 2) * oy] = m ? s / 4 : s;
      end
    end
  endtask

  task automatic check_pass(input int i, input logic m, input int exp_done);
    string s;
    int r;
    s = (i == 0) ? "lat2" : "lat1";
    r = m ? W * H : W * H / 4;
    for (int k = 0; k < NO; k++) chk($sformatf("%s dst[%0d]", s, k), int'(cap[i][k]), exp_dst[k]);
    chk({s, " write count"}, wr_cnt[i], NO);
    chk({s, " write addr order errors"}, wr_err[i], 0);
    chk({s, " read count"}, rd_cnt[i], r);
    chk({s, " first read cycle"}, rd_first[i], 1);
    chk({s, " last read cycle"}, rd_last[i], r);
    chk({s, " read addr errors"}, rd_err[i], 0);
    chk({s, " done pulses"}, done_cnt[i], 1);
    chk({s, " done cycle"}, done_cyc[i], exp_done);
    chk({s, " busy first cycle"}, busy_first[i], 1);
    chk({s, " busy last cycle"}, busy_last[i], exp_done - 1);
    chk({s, " busy during done"}, busy_at_done[i], 0);
  endtask

  // pert: 0 none, 1 start/mode toggles at cycles 3 and 5, 2 random toggles during ISSUE,
  // 3 start on instance a during its DONE cycle
  task automatic run_pass(input logic m, input int pert, input bit skip_edge);
    int r;
    r = m ? W * H : W * H / 4;
    clear_mon();
    if (!skip_edge) begin
      @(posedge clk); #1;
    end
    t0 = gcyc; start_a = 1'b1; start_b = 1'b1; mode = m; active = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      if (pert == 1 && (c == 3 || c == 5)) begin
        start_a = 1'b1; start_b = 1'b1; mode = ~mode;
      end
      if (pert == 2 && c >= 2 && c <= r) begin
        start_a = 1'($urandom_range(0, 1)); start_b = start_a; mode = 1'($urandom_range(0, 1));
      end
      if (pert == 3 && c == r + 4) start_a = 1'b1;
      if (done_cnt[0] > 0 && done_cnt[1] > 0 && c >= r + 10) break;
    end
    start_a = 1'b0; start_b = 1'b0; active = 1'b0;
  endtask

  task automatic load_pattern(input int pat);
    for (int a = 0; a < W * H; a++) begin
      if (pat == 0) src_mem[a] = 8'(a);
      else if (pat == 1) src_mem[a] = 8'd255;
      else src_mem[a] = 8'($urandom_range(0, 255));
    end
  endtask

  typedef struct {
    logic        m;
    int          pat;
    int          pert;
    logic [31:0] dst;
    int          done_a;
    int          done_b;
  } vec_t;

  vec_t tbl[5];
  logic rm;

  initial begin
    tbl[0] = '{1'b0, 0, 0, {8'd10, 8'd8, 8'd2, 8'd0}, 8, 7};
    tbl[1] = '{1'b1, 0, 0, {8'd12, 8'd10, 8'd4, 8'd2}, 20, 19};
    tbl[2] = '{1'b1, 1, 0, {8'd255, 8'd255, 8'd255, 8'd255}, 20, 19};
    tbl[3] = '{1'b0, 0, 1, {8'd10, 8'd8, 8'd2, 8'd0}, 8, 7};
    tbl[4] = '{1'b0, 0, 3, {8'd10, 8'd8, 8'd2, 8'd0}, 8, 7};

    clear_mon();
    load_pattern(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs lat2", int'({busy_a, done_a, en_a, we_a, saddr_a, daddr_a, ddata_a}), 0);
    chk("reset outputs lat1", int'({busy_b, done_b, en_b, we_b, saddr_b, daddr_b, ddata_b}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Constant vectors; the first start coincides with the reset-release cycle
    for (int i = 0; i < 5; i++) begin
      load_pattern(tbl[i].pat);
      build_model(tbl[i].m);
      for (int k = 0; k < NO; k++) exp_dst[k] = int'(tbl[i].dst[k * 8 +: 8]);
      run_pass(tbl[i].m, tbl[i].pert, i == 0);
      check_pass(0, tbl[i].m, tbl[i].done_a);
      check_pass(1, tbl[i].m, tbl[i].done_b);
    end

    // Reset at cycle 5 of an averaging pass
    load_pattern(0);
    clear_mon();
    build_model(1'b1);
    @(posedge clk); #1;
    t0 = gcyc; start_a = 1'b1; start_b = 1'b1; mode = 1'b1; active = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mid-pass reset outputs lat2",
        int'({busy_a, done_a, en_a, we_a, saddr_a, daddr_a, ddata_a}), 0);
    chk("mid-pass reset outputs lat1",
        int'({busy_b, done_b, en_b, we_b, saddr_b, daddr_b, ddata_b}), 0);
    wr_cnt[0] = 0; wr_cnt[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("writes after abort lat2", wr_cnt[0], 0);
    chk("writes after abort lat1", wr_cnt[1], 0);
    chk("busy after abort", int'({busy_a, busy_b}), 0);
    active = 1'b0;
    for (int k = 0; k < NO; k++) exp_dst[k] = int'(tbl[1].dst[k * 8 +: 8]);
    run_pass(1'b1, 0, 1'b0);
    check_pass(0, 1'b1, tbl[1].done_a);
    check_pass(1, 1'b1, tbl[1].done_b);

    // Random images and modes against the reference model
    for (int it = 0; it < 8; it++) begin
      load_pattern(2);
      rm = 1'($urandom_range(0, 1));
      build_model(rm);
      run_pass(rm, (it % 2 == 1) ? 2 : 0, 1'b0);
      check_pass(0, rm, (rm ? W * H : W * H / 4) + 2 + 2);
      check_pass(1, rm, (rm ? W * H : W * H / 4) + 2 + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pyramid_downsampler.md
PYRAMID_DOWNSAMPLER -- requirements
Module: pyramid_downsampler

Interface
REQ-001 SHALL have parameter WIDTH, default 64: source image width in pixels; even, >=2.
REQ-002 SHALL have parameter HEIGHT, default 64: source image height in pixels; even, >=2.
REQ-003 SHALL have parameter BIT_DEPTH, default 8: pixel width.
REQ-004 SHALL have parameter RD_LATENCY, default 2: source BRAM read latency in cycles; >=1.
REQ-005 SHALL have port clk_100mhz, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: begin one downsample pass.
REQ-008 SHALL have port mode, input, 1: 0 = decimate, 1 = 2x2 box average; sampled with start.
REQ-009 SHALL have port busy, output, 1: pass in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pass-complete pulse.
REQ-011 SHALL have port src_addr, output, $clog2(WIDTH*HEIGHT): source read address, raster order, x + WIDTH*y.
REQ-012 SHALL have port src_en, output, 1: source read enable.
REQ-013 SHALL have port src_data, input, BIT_DEPTH: source read data, valid RD_LATENCY cycles after src_en.
REQ-014 SHALL have port dst_addr, output, $clog2(WIDTH*HEIGHT/4): destination write address, raster order over the (WIDTH/2)x(HEIGHT/2) output.
REQ-015 SHALL have port dst_data, output, BIT_DEPTH: destination write data.
REQ-016 SHALL have port dst_we, output, 1: destination write enable.

Function
REQ-017 SHALL implement states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on start; ISSUE->DRAIN after last read issued; DRAIN->DONE after last write; DONE->IDLE unconditionally.
REQ-018 SHALL latch mode on accepted start; later mode changes have no effect until the next pass.
REQ-019 SHALL ignore start in ISSUE, DRAIN and DONE; a start asserted in DONE is not queued.
REQ-020 SHALL issue exactly one read per cycle in ISSUE (src_en=1), with no gaps; src_en=0 in all other states.
REQ-021 Decimate: reads (2x, 2y) for output y in 0..HEIGHT/2-1 (outer), x in 0..WIDTH/2-1 (inner); R = WIDTH*HEIGHT/4 reads.
REQ-022 Average: per output pixel, reads (2x,2y), (2x+1,2y), (2x,2y+1), (2x+1,2y+1) in that order; R = WIDTH*HEIGHT reads.
REQ-023 Average: SHALL sum four samples in BIT_DEPTH+2 bits and write sum>>2 (truncate); no overflow or saturation possible.
REQ-024 SHALL track in-flight reads with a RD_LATENCY-deep valid/last-of-group shift register; src_data is sampled only when the tagged valid emerges.
REQ-025 Timing: start sampled at cycle 0; read k issued at cycle 1+k; its data sampled at cycle 1+k+RD_LATENCY; the write for a group whose last read is k asserts dst_we at cycle 2+k+RD_LATENCY (registered).
REQ-026 dst_addr SHALL start at 0 and increment by 1 after each write; exactly WIDTH*HEIGHT/4 writes per pass.
REQ-027 busy SHALL be 1 from cycle 1 through the last-write cycle R+1+RD_LATENCY; done=1 only at cycle R+2+RD_LATENCY, with busy=0 in that cycle.
REQ-028 src_addr, dst_addr and dst_data SHALL hold their last values when the respective enable is 0.

Reset
REQ-029 On sys_rst_n=0, SHALL immediately enter IDLE with busy, done, src_en, dst_we, src_addr, dst_addr, dst_data, accumulator and valid pipeline all 0.
REQ-030 Reset mid-pass SHALL abort it: no further dst_we until a new start after release; in-flight reads discarded.
REQ-031 First start SHALL be accepted in the first cycle after reset release.

Verification
REQ-032 W=H=4, BIT_DEPTH=8, RD_LATENCY=2, src[a]=a, mode=0 -> dst[0..3]=0,2,8,10; done at cycle 8.
REQ-033 Same with mode=1 -> dst[0..3]=2,4,10,12 (sums 10,18,42,50); done at cycle 20; src_en continuous cycles 1-16.
REQ-034 mode=1, all src=255 -> every dst=255 (sum 1020>>2).
REQ-035 Start and mode toggled at cycles 3 and 5 of a mode-0 pass -> ignored; single done at cycle 8; writes identical to REQ-032.
REQ-036 sys_rst_n low at cycle 5 of a mode-1 pass -> all outputs 0 the same cycle; no dst_we after; new start yields REQ-033 results.
REQ-037 RD_LATENCY=1, mode=0 -> same data as REQ-032, done at cycle 7.
